// File: rtl/mux_arb_nx1_pkg.sv
// Shared definitions for the N-to-1 registered mux/arbiter.
// Holds the mode encoding and the select-width helper.
package mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    // $clog2 with a floor of 1 so a 2-input mux still gets a 1-bit index
    function automatic int sel_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mux_arb_nx1_if.sv
// Producer/consumer bundle for mux_arb_nx1.
// Ports: mode, sel, in_valid/in_data/in_ready, out_valid/out_data/out_src/out_ready.
interface mux_arb_nx1_if #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4,
    parameter int SELW  = mux_pkg::sel_w(N_IN)
);
    import mux_pkg::*;

    logic                  mode;
    logic [SELW-1:0]       sel;
    logic [N_IN-1:0]       in_valid;
    logic [N_IN*WIDTH-1:0] in_data;
    logic [N_IN-1:0]       in_ready;
    logic                  out_valid;
    logic [WIDTH-1:0]      out_data;
    logic [SELW-1:0]       out_src;
    logic                  out_ready;

    // Block side
    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_src
    );

    // Producer/consumer side
    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_src
    );

endinterface

// File: rtl/mux_arb_nx1_rr_pick.sv
// Combinational rotate-priority picker: first set req bit at or after ptr.
// Ports: req, ptr in; one-hot gnt, its index idx, and any out.
module rr_pick
    import mux_pkg::*;
#(
    parameter int N  = 4,
    parameter int SW = sel_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [SW-1:0] idx,
    output logic          any
);

    logic [SW-1:0] slot;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        slot = '0;
        for (int k = 0; k < N; k++) begin
            slot = SW'((int'(ptr) + k) % N);
            if (!any && req[slot]) begin
                any       = 1'b1;
                idx       = slot;
                gnt[slot] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_nx1.sv
// N-input registered mux with fixed-select or round-robin arbitration.
// Ports: clk, rst (sync, active-high), bus (mux_arb_nx1_if.slave).
module mux_arb_nx1
    import mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4
) (
    input  logic          clk,
    input  logic          rst,
    mux_arb_nx1_if.slave  bus
);

    localparam int SELW = sel_w(N_IN);
    localparam int NPAD = 2 ** SELW;

    logic [SELW-1:0]  ptrQ;
    logic             outValidQ;
    logic [WIDTH-1:0] outDataQ;
    logic [SELW-1:0]  outSrcQ;

    logic [N_IN-1:0]  rrGnt;
    logic [SELW-1:0]  rrIdx;
    logic             rrAny;

    logic [NPAD-1:0]  validPad;
    logic             fixAny;
    logic [N_IN-1:0]  fixGnt;
    logic             isRr;
    logic             candAny;
    logic [SELW-1:0]  candIdx;
    logic             canLoad;
    logic             grant;
    logic [N_IN-1:0]  inReady;
    logic [SELW-1:0]  ptrNext;

    rr_pick #(
        .N  (N_IN),
        .SW (SELW)
    ) uPick (
        .req (bus.in_valid),
        .ptr (ptrQ),
        .gnt (rrGnt),
        .idx (rrIdx),
        .any (rrAny)
    );

    // Padding to a power of two lets sel index safely when
    // N_IN is not a power of two; out-of-range sel reads 0.
    assign validPad = NPAD'(bus.in_valid);
    assign fixAny   = (int'(bus.sel) < N_IN) && validPad[bus.sel];
    assign fixGnt   = N_IN'(1) << bus.sel;

    assign isRr    = (bus.mode == MODE_RR);
    assign candAny = isRr ? rrAny : fixAny;
    assign candIdx = isRr ? rrIdx : bus.sel;

    // Drain and reload in one cycle is allowed
    assign canLoad = !outValidQ || bus.out_ready;
    assign grant   = candAny && canLoad && !rst;

    always_comb begin
        inReady = '0;
        if (grant) begin
            inReady = isRr ? rrGnt : fixGnt;
        end
    end

    assign ptrNext = (candIdx == SELW'(N_IN - 1))
                   ? '0 : candIdx + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            outValidQ <= 1'b0;
            outDataQ  <= '0;
            outSrcQ   <= '0;
            ptrQ      <= '0;
        end else if (grant) begin
            outValidQ <= 1'b1;
            outDataQ  <= bus.in_data[int'(candIdx)*WIDTH +: WIDTH];
            outSrcQ   <= candIdx;
            if (isRr) begin
                ptrQ <= ptrNext;
            end
        end else if (outValidQ && bus.out_ready) begin
            outValidQ <= 1'b0;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValidQ;
    assign bus.out_data  = outDataQ;
    assign bus.out_src   = outSrcQ;

endmodule

// File: tb/tb_mux_arb_nx1.sv
// Self-checking bench for mux_arb_nx1 (N_IN=4 and N_IN=3 instances).
// Table vectors, directed corner sequences and random traffic vs a model.
module tb_mux_arb_nx1;
    import mux_pkg::*;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int N3 = 3;

    logic clk = 1'b0;
    logic rst4;
    logic rst3;
    always #5 clk = ~clk;

    mux_arb_nx1_if #(.WIDTH(W), .N_IN(N))  b4 ();
    mux_arb_nx1_if #(.WIDTH(W), .N_IN(N3)) b3 ();

    mux_arb_nx1 #(.WIDTH(W), .N_IN(N)) dut4 (
        .clk (clk),
        .rst (rst4),
        .bus (b4.slave)
    );

    mux_arb_nx1 #(.WIDTH(W), .N_IN(N3)) dut3 (
        .clk (clk),
        .rst (rst3),
        .bus (b3.slave)
    );

    int nTests = 0;
    int nFail  = 0;

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: output register contents and RR pointer
    bit          mValid = 0;
    logic [31:0] mData  = '0;
    int          mSrc   = 0;
    int          mPtr   = 0;

    function automatic int modelCand();
        int s;
        if (b4.mode == MODE_FIXED) begin
            s = int'(b4.sel);
            if (s < N && b4.in_valid[s]) return s;
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            s = (mPtr + k) % N;
            if (b4.in_valid[s]) return s;
        end
        return -1;
    endfunction

    function automatic bit modelGrant(input int g);
        return !rst4 && g >= 0 && (!mValid || b4.out_ready);
    endfunction

    // One clock on dut4 with full model checking
    task automatic tick4();
        int          g;
        bit          gr;
        logic [3:0]  expRdy;
        logic [31:0] d;
        logic        rr;
        logic        ordy;
        logic        r;
        #2;
        g      = modelCand();
        gr     = modelGrant(g);
        expRdy = gr ? 4'(1 << g) : 4'b0;
        d      = gr ? b4.in_data[g*W +: W] : 32'h0;
        rr     = b4.mode;
        ordy   = b4.out_ready;
        r      = rst4;
        check("m_in_ready", 64'(b4.in_ready), 64'(expRdy));
        @(posedge clk);
        if (r) begin
            mValid = 0; mData = '0; mSrc = 0; mPtr = 0;
        end else if (gr) begin
            mValid = 1; mData = d; mSrc = g;
            if (rr == MODE_RR) mPtr = (g + 1) % N;
        end else if (mValid && ordy) begin
            mValid = 0;
        end
        #1;
        check("m_out_valid", 64'(b4.out_valid), 64'(mValid));
        check("m_out_data",  64'(b4.out_data),  64'(mData));
        check("m_out_src",   64'(b4.out_src),   64'(mSrc));
    endtask

    task automatic reset4();
        rst4 = 1'b1;
        tick4();
        rst4 = 1'b0;
    endtask

    function automatic logic [31:0] dOf(input int i);
        return 32'hA000_0000 + 32'(i);
    endfunction

    task automatic setData4();
        for (int i = 0; i < N; i++) b4.in_data[i*W +: W] = dOf(i);
    endtask

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] valid;
        logic       oRdy;
        logic [3:0] expRdy;
        logic       expValid;
        logic [1:0] expSrc;
    } vec_t;

    vec_t tbl[9];
    int   seq3[9];
    logic [31:0] expD;

    initial begin
        tbl[0] = '{1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[1] = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[2] = '{1'b0, 2'd3, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[3] = '{1'b0, 2'd1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[4] = '{1'b1, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};
        tbl[5] = '{1'b1, 2'd3, 4'b0110, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[6] = '{1'b1, 2'd0, 4'b1000, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[7] = '{1'b1, 2'd2, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[8] = '{1'b0, 2'd2, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2};
        seq3 = '{0, 1, 2, 3, 0, 1, 2, 3, 0};

        b4.mode = MODE_RR; b4.sel = '0; b4.in_valid = '1;
        b4.out_ready = 1'b1; setData4();
        b3.mode = MODE_FIXED; b3.sel = 2'd3; b3.in_valid = '1;
        b3.out_ready = 1'b1;
        for (int i = 0; i < N3; i++) b3.in_data[i*W +: W] = dOf(i + 8);
        rst3 = 1'b1;

        // Reset held 2 cycles with all inputs valid
        rst4 = 1'b1;
        tick4();
        tick4();
        check("rst_valid", 64'(b4.out_valid), 64'd0);
        check("rst_data",  64'(b4.out_data),  64'd0);
        check("rst_src",   64'(b4.out_src),   64'd0);
        check("rst_ready", 64'(b4.in_ready),  64'd0);
        rst4 = 1'b0;
        tick4();
        check("first_rr_valid", 64'(b4.out_valid), 64'd1);
        check("first_rr_src",   64'(b4.out_src),   64'd0);

        // Table vectors, each from a fresh EMPTY state with ptr=0
        for (int t = 0; t < 9; t++) begin
            reset4();
            b4.mode      = tbl[t].mode;
            b4.sel       = tbl[t].sel;
            b4.in_valid  = tbl[t].valid;
            b4.out_ready = tbl[t].oRdy;
            #2;
            check($sformatf("tbl%0d_ready", t),
                  64'(b4.in_ready), 64'(tbl[t].expRdy));
            tick4();
            expD = tbl[t].expValid ? dOf(int'(tbl[t].expSrc)) : 32'h0;
            check($sformatf("tbl%0d_valid", t),
                  64'(b4.out_valid), 64'(tbl[t].expValid));
            check($sformatf("tbl%0d_src", t),
                  64'(b4.out_src), 64'(tbl[t].expSrc));
            check($sformatf("tbl%0d_data", t),
                  64'(b4.out_data), 64'(expD));
        end

        // Fixed sel=2, continuous stream
        b4.out_ready = 1'b1; b4.in_valid = '1;
        reset4();
        b4.mode = MODE_FIXED; b4.sel = 2'd2;
        for (int k = 0; k < 4; k++) begin
            b4.in_data[2*W +: W] = 32'hDEADBEEF + 32'(k);
            #2;
            check("fix_ready", 64'(b4.in_ready), 64'b0100);
            tick4();
            check("fix_valid", 64'(b4.out_valid), 64'd1);
            check("fix_data",  64'(b4.out_data),
                  64'(32'hDEADBEEF + 32'(k)));
            check("fix_src",   64'(b4.out_src), 64'd2);
        end
        setData4();

        // RR fairness with all inputs valid
        reset4();
        b4.mode = MODE_RR;
        for (int k = 0; k < 9; k++) begin
            tick4();
            check($sformatf("rr_seq%0d", k),
                  64'(b4.out_src), 64'(seq3[k]));
        end

        // RR wrap: inputs 1 and 3, ptr moved to 2 first
        reset4();
        b4.in_valid = 4'b0010;
        tick4();
        b4.in_valid = 4'b1010;
        tick4();
        check("wrap_a", 64'(b4.out_src), 64'd3);
        tick4();
        check("wrap_b", 64'(b4.out_src), 64'd1);
        tick4();
        check("wrap_c", 64'(b4.out_src), 64'd3);

        // Backpressure then no-bubble reload
        b4.in_valid = '1;
        reset4();
        tick4();
        b4.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("bp_ready", 64'(b4.in_ready), 64'd0);
            tick4();
            check("bp_src",  64'(b4.out_src),  64'd0);
            check("bp_data", 64'(b4.out_data), 64'(dOf(0)));
        end
        b4.out_ready = 1'b1;
        #2;
        check("bp_rel_ready", 64'(b4.in_ready), 64'b0010);
        tick4();
        check("bp_rel_valid", 64'(b4.out_valid), 64'd1);
        check("bp_rel_src",   64'(b4.out_src),   64'd1);

        // N_IN=3, out-of-range sel, then reset while FULL
        tick4();
        rst3 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("n3_ready", 64'(b3.in_ready), 64'd0);
            tick4();
            check("n3_valid", 64'(b3.out_valid), 64'd0);
        end
        b3.sel = 2'd1;
        #2;
        check("n3_sel1_ready", 64'(b3.in_ready), 64'b010);
        tick4();
        check("n3_sel1_valid", 64'(b3.out_valid), 64'd1);
        check("n3_sel1_src",   64'(b3.out_src),   64'd1);
        check("n3_sel1_data",  64'(b3.out_data),  64'(dOf(9)));
        b3.out_ready = 1'b0;
        rst3 = 1'b1;
        #2;
        check("n3_rst_ready", 64'(b3.in_ready), 64'd0);
        tick4();
        check("n3_rst_valid", 64'(b3.out_valid), 64'd0);

        // Random traffic against the model
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 15) == 0) b4.mode = ~b4.mode;
            b4.sel       = 2'($urandom);
            b4.in_valid  = 4'($urandom);
            for (int i = 0; i < N; i++) b4.in_data[i*W +: W] = $urandom;
            b4.out_ready = ($urandom_range(0, 3) != 0);
            rst4         = ($urandom_range(0, 49) == 0);
            tick4();
        end
        rst4 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/mux_arb_nx1.md
# mux_arb_nx1

Parametrised N-input, W-bit registered multiplexer with per-input valid/ready handshakes and two selection modes: fixed select, or round-robin arbitration. It generalises the 4-to-1, 32-bit combinational select mux used on the datapath. It sits between several producers (ALU result, immediate, memory read, forwarding paths) and a single consumer stage. Holding data in an output register gives it flow control.

## Interface
Parameters:
- `WIDTH`, 32, data width per input.
- `N_IN`, 4, number of inputs. Legal range is 2..16.
- `SELW`, `$clog2(N_IN)`, select/source index width. Derived; do not override.

Ports:
- `clk`  in  1  single clock; everything is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  1  0 = fixed select (`MODE_FIXED`), 1 = round-robin (`MODE_RR`).
- `sel`  in  SELW  input index used in fixed mode; ignored in RR mode.
- `in_valid`  in  N_IN  per-input valid; bit i belongs to input i.
- `in_data`  in  N_IN*WIDTH  packed inputs; input i is `in_data[i*WIDTH +: WIDTH]`.
- `in_ready`  out  N_IN  one-hot (or zero) acceptance for this cycle.
- `out_valid`  out  1  output register holds data.
- `out_data`  out  WIDTH  registered selected data.
- `out_src`  out  SELW  index of the input that `out_data` came from.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.

## Operation
- Output register has two states. EMPTY is `out_valid=0`; FULL is `out_valid=1`.
- `can_load = !out_valid || out_ready`.
- Fixed mode:
  - Candidate is `sel` when `sel < N_IN` and `in_valid[sel]`.
  - If `sel >= N_IN` (non-power-of-2 `N_IN`), there is no candidate.
  - Other inputs are never granted.
- RR mode:
  - Candidate is the first i with `in_valid[i]=1`, scanning ptr, ptr+1, … modulo N_IN.
  - No valid input means no candidate.
- Grant = candidate exists && `can_load` && !rst. `in_ready[g]=1` only for the granted g; all other bits are 0.
- On grant: `out_data <= in_data[g]`, `out_src <= g`, `out_valid <= 1`.
- In RR mode only, a grant also sets `ptr <= (g+1) mod N_IN`. The wrap from N_IN-1 goes to 0.
- Without a grant, when `out_valid && out_ready`: `out_valid <= 0`. `out_data` and `out_src` hold their last value.
- When FULL and `out_ready=0`, all outputs hold, `in_ready` = 0, and ptr holds.
- `mode`/`sel` are sampled combinationally each cycle. Changing them never alters a value already in the output register.
- ptr is not updated in fixed mode. Switching to RR resumes from the stored ptr.
- Producers must hold `in_data[i]` stable while `in_valid[i]=1` and `in_ready[i]=0`. The block does not check this.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_src=0`, ptr=0, `in_ready=0`. `in_ready` is forced to 0 during any cycle with `rst=1`.
- Reset mid-operation: a FULL entry is discarded on the next edge, and no consumer transfer is counted.
- Latency: 1 cycle from the input handshake (`in_valid[g] && in_ready[g]`) to the data appearing with `out_valid=1`.
- Throughput: 1 transfer per cycle when `out_ready=1` continuously. A simultaneous drain and load in the same cycle is a pass-through, with no bubble.
- `in_ready` depends combinationally on `in_valid`, `mode`, `sel`, `out_ready` and state. No input-to-output combinational path exists on `out_*`.
- Fairness: in RR mode with all inputs valid and `out_ready=1`, the grant order is 0,1,…,N_IN-1,0,…

## Structure
- Package `mux_pkg`:
  - `MODE_FIXED` / `MODE_RR` constants.
  - Function `sel_w(n)` returning `$clog2` with a minimum of 1.
- Sub-module `rr_pick #(N)`:
  - Combinational rotate-priority pick.
  - Inputs: req vector and ptr. Outputs: one-hot grant, index, any.
- The top level holds the output register, ptr and grant qualification.

## Test plan
1. Reset: hold `rst=1` for 2 cycles with all `in_valid=1`. Required: `out_valid=0`, `out_data=0`, `out_src=0`, `in_ready=0`. After release (RR mode), the first grant is input 0.
2. Fixed mode, `N_IN=4`, `sel=2`, `in_data[2]=32'hDEADBEEF`, all valid, `out_ready=1`. Required: only `in_ready[2]=1`; the next cycle shows `out_data=DEADBEEF`, `out_src=2`. The stream is continuous, one per cycle.
3. RR mode, all 4 valid, `out_ready=1` for 9 cycles. Required: `out_src` sequence 0,1,2,3,0,1,2,3,0.
4. RR mode, only inputs 1 and 3 valid, ptr=2. Required: grants 3, then 1, then 3 (wrap-around).
5. Backpressure: fill the register, then `out_ready=0` for 3 cycles. Required: `out_data`/`out_src` stable, `in_ready=0`, ptr unchanged. With `out_ready=1` and input valid in the same cycle, a new value loads with no bubble.
6. `N_IN=3`, fixed mode, `sel=3`, all valid. Required: no grant, `out_valid` stays 0. Also assert `rst` while FULL: next cycle `out_valid=0`.
